// File: rtl/slide_exec.sv
// rtl/slide_exec.sv - one blank-tile slide on a 3x3 board held in an external register file.
// Optional move-history tracking is enabled by defining SLIDE_EXEC_HIST_EN.
module slide_exec #(
  parameter logic [4:0] BOARD_REG  = 5'd0,
  parameter logic [4:0] GOAL_REG   = 5'd1,
  parameter logic [4:0] RESULT_REG = 5'd2,
  parameter logic [4:0] HIST_REG   = 5'd3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  dir,
  output logic [4:0]  src0,
  output logic [4:0]  src1,
  input  logic [39:0] data0,
  input  logic [39:0] data1,
  output logic [4:0]  dst,
  output logic        we,
  output logic [39:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        legal,
  output logic        solved
);

  typedef enum logic [2:0] {IDLE, READ, CALC, WRITE, DONE, HIST_RD, HIST_WR} state_t;

  state_t      state, state_n;
  logic [1:0]  dir_q;
  logic [39:0] board_q, goal_q, result_q, new_board;
  logic        legal_c, calc_legal, bad_dir;
  logic [3:0]  p, q, tile;

`ifdef SLIDE_EXEC_HIST_EN
  logic [33:0] hist_q;
  logic        hist_ok;
  logic [4:0]  slot;
  logic [39:0] hist_new;

  assign slot     = {hist_q[33:30], 1'b0};
  assign hist_new = {6'b0, hist_q[33:30] + 4'd1,
                     (hist_q[29:0] & ~(30'd3 << slot)) | (30'(dir_q) << slot)};
`else
  logic unused_hist;
  assign unused_hist = ^HIST_REG;
`endif

  // Legality and the slid board are derived from the captured board only.
  always_comb begin
    p         = board_q[39:36];
    q         = 4'd0;
    bad_dir   = 1'b0;
    tile      = 4'd0;
    new_board = board_q;
    case (dir_q)
      2'b00: begin bad_dir = (p < 4'd3);           q = p - 4'd3; end
      2'b01: begin bad_dir = (p > 4'd5);           q = p + 4'd3; end
      2'b10: begin bad_dir = ((p % 4'd3) == 4'd0); q = p - 4'd1; end
      default: begin bad_dir = ((p % 4'd3) == 4'd2); q = p + 4'd1; end
    endcase
    calc_legal = (p <= 4'd8) && !bad_dir;
    for (int k = 0; k < 9; k++)
      if (q == 4'(k)) tile = board_q[35-4*k -: 4];
    new_board[39:36] = q;
    for (int k = 0; k < 9; k++) begin
      if (p == 4'(k))      new_board[35-4*k -: 4] = tile;
      else if (q == 4'(k)) new_board[35-4*k -: 4] = 4'd0;
    end
  end

  always_comb begin
    state_n = state;
    src0    = BOARD_REG;
    src1    = GOAL_REG;
    dst     = 5'd0;
    we      = 1'b0;
    wdata   = 40'd0;
    done    = 1'b0;
    busy    = (state != IDLE);
    case (state)
      IDLE:  if (start) state_n = READ;
      READ:  state_n = CALC;
`ifdef SLIDE_EXEC_HIST_EN
      CALC:  state_n = HIST_RD;
      HIST_RD: begin
        src0    = HIST_REG;
        state_n = WRITE;
      end
      HIST_WR: begin
        we      = 1'b1;
        dst     = HIST_REG;
        wdata   = hist_new;
        state_n = DONE;
      end
`else
      CALC:  state_n = WRITE;
`endif
      WRITE: begin
        if (legal_c) begin
          we    = 1'b1;
          dst   = RESULT_REG;
          wdata = result_q;
        end
`ifdef SLIDE_EXEC_HIST_EN
        state_n = hist_ok ? HIST_WR : DONE;
`else
        state_n = DONE;
`endif
      end
      DONE: begin
        done    = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      dir_q    <= 2'd0;
      board_q  <= 40'd0;
      goal_q   <= 40'd0;
      result_q <= 40'd0;
      legal_c  <= 1'b0;
      legal    <= 1'b0;
      solved   <= 1'b0;
`ifdef SLIDE_EXEC_HIST_EN
      hist_q   <= 34'd0;
      hist_ok  <= 1'b0;
`endif
    end else begin
      state <= state_n;
      case (state)
        IDLE: if (start) begin
          dir_q  <= dir;
          legal  <= 1'b0;
          solved <= 1'b0;
        end
        READ: begin
          board_q <= data0;
          goal_q  <= data1;
        end
        CALC: begin
          legal_c  <= calc_legal;
          result_q <= calc_legal ? new_board : board_q;
        end
`ifdef SLIDE_EXEC_HIST_EN
        HIST_RD: begin
          hist_q  <= data0[33:0];
          hist_ok <= (data0[33:30] != 4'd15);
          // A full history forces the move illegal: neither board nor history is written.
          if (data0[33:30] == 4'd15) begin
            legal_c  <= 1'b0;
            result_q <= board_q;
          end
        end
`endif
        default: ;
      endcase
      // Status becomes visible in the same cycle done pulses.
      if (state_n == DONE) begin
        legal  <= legal_c;
        solved <= (result_q == goal_q);
      end
    end
  end

endmodule

// File: tb/tb_slide_exec.sv
// tb/tb_slide_exec.sv - scoreboard bench for slide_exec with a behavioural register file.
module tb_slide_exec;
  logic        clk = 1'b0;
  logic        rst, start, we, busy, done, legal, solved;
  logic [1:0]  dir;
  logic [4:0]  src0, src1, dst;
  logic [39:0] data0, data1, wdata;
  logic [39:0] regs [0:31];

  localparam logic [39:0] INIT = 40'h5123450786;
  localparam logic [39:0] GOAL = 40'h8123456780;
  localparam logic [39:0] P0   = 40'h0012345678;
  localparam int LAT = 3;

  typedef struct { logic [4:0] d; logic [39:0] v; } wr_t;
  typedef struct { logic lg; logic sv; int lat; } dn_t;
  wr_t wq[$];
  dn_t dq[$];
  int  n_vec = 0, n_err = 0, cyc = 0, acc_cyc = 0;

  slide_exec dut (
    .clk(clk), .rst(rst), .start(start), .dir(dir),
    .src0(src0), .src1(src1), .data0(data0), .data1(data1),
    .dst(dst), .we(we), .wdata(wdata),
    .busy(busy), .done(done), .legal(legal), .solved(solved)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  assign data0 = regs[src0];
  assign data1 = regs[src1];
  always @(posedge clk) if (we) regs[dst] <= wdata;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    wr_t ew;
    dn_t ed;
    if (we) begin
      if (wq.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL unexpected_write: dst %0d data %h, expected no write", dst, wdata);
      end else begin
        ew = wq.pop_front();
        check("wr_dst", 64'(dst), 64'(ew.d));
        check("wr_data", 64'(wdata), 64'(ew.v));
      end
    end
    if (done) begin
      if (dq.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL unexpected_done: got done=1, expected no done");
      end else begin
        ed = dq.pop_front();
        check("legal", 64'(legal), 64'(ed.lg));
        check("solved", 64'(solved), 64'(ed.sv));
        check("latency", 64'(cyc - acc_cyc), 64'(ed.lat));
      end
    end
  end

  task automatic move(input logic [39:0] b, input logic [39:0] g, input logic [1:0] d,
                      input logic lg, input logic sv, input logic [39:0] res,
                      input bit hw, input logic [39:0] hval, input int lat, input bit extra);
    logic [39:0] prev;
    bit seen;
    regs[0] = b;
    regs[1] = g;
    prev = regs[2];
    if (lg) wq.push_back('{5'd2, res});
    if (hw) wq.push_back('{5'd3, hval});
    dq.push_back('{lg, sv, lat});
    dir = d;
    start = 1'b1;
    @(posedge clk); #1;
    acc_cyc = cyc;
    start = 1'b0;
    check("busy_run", 64'(busy), 64'd1);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) begin seen = 1'b1; break; end
      @(posedge clk); #1;
      start = extra && (i < 2);
    end
    start = 1'b0;
    check("done_seen", 64'(seen), 64'd1);
    @(posedge clk); #1;
    check("busy_idle", 64'(busy), 64'd0);
    check("reg2", 64'(regs[2]), 64'(lg ? res : prev));
    repeat (2) @(posedge clk);
    #1 check("legal_held", 64'(legal), 64'(lg));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = 40'd0;
    regs[2] = 40'hA5A5A5A5A5;
    rst = 1'b1; start = 1'b0; dir = 2'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_we", 64'(we), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_legal", 64'(legal), 64'd0);
    check("rst_solved", 64'(solved), 64'd0);
    check("rst_dst", 64'(dst), 64'd0);
    check("rst_wdata", 64'(wdata), 64'd0);
    check("rst_src0", 64'(src0), 64'd0);
    check("rst_src1", 64'(src1), 64'd1);
    rst = 1'b0;
    @(posedge clk); #1;

`ifdef SLIDE_EXEC_HIST_EN
    regs[3] = 40'h0080000004;
    move(INIT, GOAL, 2'b10, 1'b1, 1'b0, 40'h4123405786, 1'b1, 40'h00C0000024, 5, 1'b0);
    check("hist_reg", 64'(regs[3]), 64'h00C0000024);
    regs[3] = 40'h03C0000000;
    move(INIT, GOAL, 2'b01, 1'b0, 1'b0, 40'd0, 1'b0, 40'd0, 4, 1'b0);
    check("hist_full", 64'(regs[3]), 64'h03C0000000);
`else
    move(INIT, GOAL, 2'b01, 1'b1, 1'b1, GOAL, 1'b0, 40'd0, LAT, 1'b0);
    regs[2] = 40'hA5A5A5A5A5;
    move(INIT, GOAL, 2'b11, 1'b0, 1'b0, 40'd0, 1'b0, 40'd0, LAT, 1'b0);
    move(P0, GOAL, 2'b00, 1'b0, 1'b0, 40'd0, 1'b0, 40'd0, LAT, 1'b0);
    move(P0, GOAL, 2'b10, 1'b0, 1'b0, 40'd0, 1'b0, 40'd0, LAT, 1'b0);
    move(P0, GOAL, 2'b01, 1'b1, 1'b0, 40'h3312045678, 1'b0, 40'd0, LAT, 1'b0);
    move(P0, P0, 2'b00, 1'b0, 1'b1, 40'd0, 1'b0, 40'd0, LAT, 1'b0);
    move(40'h9123456780, GOAL, 2'b00, 1'b0, 1'b0, 40'd0, 1'b0, 40'd0, LAT, 1'b0);
    move(GOAL, GOAL, 2'b01, 1'b0, 1'b1, 40'd0, 1'b0, 40'd0, LAT, 1'b0);
    move(40'h4123405678, GOAL, 2'b10, 1'b1, 1'b0, 40'h3123045678, 1'b0, 40'd0, LAT, 1'b0);
    move(40'h3123045678, GOAL, 2'b11, 1'b1, 1'b0, 40'h4123405678, 1'b0, 40'd0, LAT, 1'b0);
    move(40'h2120345678, GOAL, 2'b11, 1'b0, 1'b0, 40'd0, 1'b0, 40'd0, LAT, 1'b0);
    move(40'h6123456078, GOAL, 2'b10, 1'b0, 1'b0, 40'd0, 1'b0, 40'd0, LAT, 1'b0);
    move(40'h6123456078, GOAL, 2'b00, 1'b1, 1'b0, 40'h3123056478, 1'b0, 40'd0, LAT, 1'b0);
    move(INIT, GOAL, 2'b01, 1'b1, 1'b1, GOAL, 1'b0, 40'd0, LAT, 1'b1);

    // Reset while the write port is active: the write in flight is the last one.
    regs[0] = INIT; regs[1] = GOAL; regs[2] = 40'd0;
    wq.push_back('{5'd2, GOAL});
    dir = 2'b01; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (2) @(posedge clk);
    #1 check("we_in_write", 64'(we), 64'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_mid_we", 64'(we), 64'd0);
    check("rst_mid_busy", 64'(busy), 64'd0);
    rst = 1'b0;
    repeat (6) @(posedge clk);
    #1 check("rst_mid_legal", 64'(legal), 64'd0);
    move(INIT, GOAL, 2'b01, 1'b1, 1'b1, GOAL, 1'b0, 40'd0, LAT, 1'b0);
`endif

    repeat (3) @(posedge clk);
    #1;
    check("wq_empty", 64'(wq.size()), 64'd0);
    check("dq_empty", 64'(dq.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
